// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers results from N_SRC functional units in per-source
// FIFOs and issues at most one register-file write per cycle, round-robin.
module wb_arbiter #(
    parameter int N_SRC      = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_SRC-1:0]       src_valid,
    output logic [N_SRC-1:0]       src_ready,
    input  logic [N_SRC-1:0][4:0]  src_rd_s,
    input  logic [N_SRC-1:0][31:0] src_rd_v,
    output logic                   regf_we,
    output logic [4:0]             rd_s,
    output logic [31:0]            rd_v,
    output logic                   fifo_empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = $clog2(N_SRC);

    logic [PTR_W-1:0] rd_ptr [N_SRC];
    logic [PTR_W-1:0] wr_ptr [N_SRC];
    logic [CNT_W-1:0] cnt    [N_SRC];
    logic [4:0]       mem_s  [N_SRC][FIFO_DEPTH];
    logic [31:0]      mem_v  [N_SRC][FIFO_DEPTH];

    logic [N_SRC-1:0] push;
    logic [N_SRC-1:0] pop;
    logic [N_SRC-1:0] nonempty;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] cand;
    logic             gnt_vld;
    logic [4:0]       head_s;
    logic [31:0]      head_v;

    // Ready comes from the registered count only; writes to x0 are swallowed here.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            nonempty[i]  = (cnt[i] != '0);
            src_ready[i] = (cnt[i] != CNT_W'(FIFO_DEPTH));
            push[i]      = src_valid[i] && src_ready[i] && (src_rd_s[i] != 5'd0);
        end
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = last;
        cand    = last;
        for (int k = 1; k <= N_SRC; k++) begin
            cand = IDX_W'((int'(last) + k) % N_SRC);
            if (!gnt_vld && nonempty[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            pop[i] = gnt_vld && (gnt_idx == IDX_W'(i));
        end
        head_s = mem_s[gnt_idx][rd_ptr[gnt_idx]];
        head_v = mem_v[gnt_idx][rd_ptr[gnt_idx]];
    end

    assign fifo_empty = ~|nonempty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
            last <= IDX_W'(N_SRC - 1);
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                if (push[i] && !pop[i])
                    cnt[i] <= cnt[i] + 1'b1;
                else if (!push[i] && pop[i])
                    cnt[i] <= cnt[i] - 1'b1;
            end
            if (gnt_vld) last <= gnt_idx;
        end
    end

    // FIFO storage is data only; validity is tracked by the counts.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (push[i]) begin
                mem_s[i][wr_ptr[i]] <= src_rd_s[i];
                mem_v[i][wr_ptr[i]] <= src_rd_v[i];
            end
        end
    end

    // Registered write port: zeroed whenever there is no grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regf_we <= 1'b0;
            rd_s    <= '0;
            rd_v    <= '0;
        end else begin
            regf_we <= gnt_vld;
            rd_s    <= gnt_vld ? head_s : 5'd0;
            rd_v    <= gnt_vld ? head_v : 32'd0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: vector tables plus hand-written sequences for
// reset, backpressure and pointer wrap.
module tb_wb_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       src_valid;
    logic [2:0]       src_ready;
    logic [2:0][4:0]  src_rd_s;
    logic [2:0][31:0] src_rd_v;
    logic             regf_we;
    logic [4:0]       rd_s;
    logic [31:0]      rd_v;
    logic             fifo_empty;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.N_SRC(3), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .src_valid(src_valid),
        .src_ready(src_ready),
        .src_rd_s(src_rd_s),
        .src_rd_v(src_rd_v),
        .regf_we(regf_we),
        .rd_s(rd_s),
        .rd_v(rd_v),
        .fifo_empty(fifo_empty)
    );

    typedef struct {
        logic [2:0]  valid;
        logic [4:0]  s0, s1, s2;
        logic [31:0] v0, v1, v2;
        logic        we;
        logic [4:0]  es;
        logic [31:0] ev;
        logic [2:0]  erdy;
        logic        eempty;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] valid,
                                input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                                input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2,
                                input logic we, input logic [4:0] es, input logic [31:0] ev,
                                input logic [2:0] erdy, input logic eempty);
        vec_t t;
        t.valid = valid; t.s0 = s0; t.s1 = s1; t.s2 = s2;
        t.v0 = v0; t.v1 = v1; t.v2 = v2;
        t.we = we; t.es = es; t.ev = ev; t.erdy = erdy; t.eempty = eempty;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] valid,
                         input logic [4:0] s0, input logic [31:0] v0,
                         input logic [4:0] s1, input logic [31:0] v1,
                         input logic [4:0] s2, input logic [31:0] v2);
        src_valid   = valid;
        src_rd_s[0] = s0; src_rd_v[0] = v0;
        src_rd_s[1] = s1; src_rd_v[1] = v1;
        src_rd_s[2] = s2; src_rd_v[2] = v2;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t t, input string tag, input int idx);
        drive(t.valid, t.s0, t.v0, t.s1, t.v1, t.s2, t.v2);
        cycle();
        chk($sformatf("%s[%0d].we", tag, idx),    32'(regf_we),    32'(t.we));
        chk($sformatf("%s[%0d].rd_s", tag, idx),  32'(rd_s),       32'(t.es));
        chk($sformatf("%s[%0d].rd_v", tag, idx),  rd_v,            t.ev);
        chk($sformatf("%s[%0d].ready", tag, idx), 32'(src_ready),  32'(t.erdy));
        chk($sformatf("%s[%0d].empty", tag, idx), 32'(fifo_empty), 32'(t.eempty));
    endtask

    task automatic do_reset();
        drive(3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        tab_a [7];
        vec_t        tab_b [5];
        logic [31:0] got [$];
        logic [4:0]  f_s  [9];
        logic        f_r0 [9];
        logic [31:0] f_v0 [9];

        // Round-robin from reset: all sources continuously valid.
        tab_a[0] = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hB0, 32'hC0, 1'b0, 5'd0, 32'h0,  3'b111, 1'b0);
        tab_a[1] = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hB0, 32'hC0, 1'b1, 5'd1, 32'hA0, 3'b111, 1'b0);
        tab_a[2] = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hB0, 32'hC0, 1'b1, 5'd2, 32'hB0, 3'b111, 1'b0);
        tab_a[3] = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hB0, 32'hC0, 1'b1, 5'd3, 32'hC0, 3'b111, 1'b0);
        tab_a[4] = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hB0, 32'hC0, 1'b1, 5'd1, 32'hA0, 3'b001, 1'b0);
        tab_a[5] = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hB0, 32'hC0, 1'b1, 5'd2, 32'hB0, 3'b010, 1'b0);
        tab_a[6] = mk(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0, 32'hB0, 32'hC0, 1'b1, 5'd3, 32'hC0, 3'b100, 1'b0);

        // Single write from source 1, then an x0 write from source 2.
        tab_b[0] = mk(3'b010, 5'd0, 5'd5, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0,    1'b0, 5'd0, 32'h0,        3'b111, 1'b0);
        tab_b[1] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0,        32'h0,    1'b1, 5'd5, 32'hDEADBEEF, 3'b111, 1'b1);
        tab_b[2] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0,        32'h0,    1'b0, 5'd0, 32'h0,        3'b111, 1'b1);
        tab_b[3] = mk(3'b100, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0,        32'h1234, 1'b0, 5'd0, 32'h0,        3'b111, 1'b1);
        tab_b[4] = mk(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0,        32'h0,    1'b0, 5'd0, 32'h0,        3'b111, 1'b1);

        // Backpressure schedule on source 0 against saturated sources 1 and 2.
        f_v0 = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd7, 32'd7};
        f_s  = '{5'd0, 5'd9, 5'd2, 5'd3, 5'd9, 5'd2, 5'd3, 5'd9, 5'd2};
        f_r0 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        drive(3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        @(negedge clk);
        chk("reset.we",    32'(regf_we),    32'd0);
        chk("reset.rd_s",  32'(rd_s),       32'd0);
        chk("reset.rd_v",  rd_v,            32'd0);
        chk("reset.ready", 32'(src_ready),  32'd7);
        chk("reset.empty", 32'(fifo_empty), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(tab_a[i], "rr", i);

        // Asynchronous reset between edges while all FIFOs hold entries.
        drive(3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst.we",    32'(regf_we),    32'd0);
        chk("async_rst.rd_s",  32'(rd_s),       32'd0);
        chk("async_rst.rd_v",  rd_v,            32'd0);
        chk("async_rst.ready", 32'(src_ready),  32'd7);
        chk("async_rst.empty", 32'(fifo_empty), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk($sformatf("post_rst[%0d].we", i), 32'(regf_we), 32'd0);
            chk($sformatf("post_rst[%0d].empty", i), 32'(fifo_empty), 32'd1);
        end

        for (int i = 0; i < 5; i++) run_vec(tab_b[i], "single_x0", i);

        do_reset();
        got.delete();
        for (int e = 0; e < 9; e++) begin
            drive(3'b111, 5'd9, f_v0[e], 5'd2, 32'h200, 5'd3, 32'h300);
            cycle();
            chk($sformatf("full[%0d].we", e),     32'(regf_we),      (e == 0) ? 32'd0 : 32'd1);
            chk($sformatf("full[%0d].rd_s", e),   32'(rd_s),         32'(f_s[e]));
            chk($sformatf("full[%0d].ready0", e), 32'(src_ready[0]), 32'(f_r0[e]));
            if (regf_we && rd_s == 5'd9) got.push_back(rd_v);
        end
        drive(3'b000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0);
        for (int c = 0; c < 40 && got.size() < 7; c++) begin
            cycle();
            if (regf_we && rd_s == 5'd9) got.push_back(rd_v);
        end
        chk("full.count", 32'(got.size()), 32'd7);
        for (int k = 0; k < got.size() && k < 7; k++)
            chk($sformatf("full.order[%0d]", k), got[k], 32'(k + 1));

        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive((i < 10) ? 3'b001 : 3'b000, 5'd4, 32'h100 + 32'(i), 5'd0, 32'd0, 5'd0, 32'd0);
            cycle();
            chk($sformatf("wrap[%0d].ready0", i), 32'(src_ready[0]), 32'd1);
            if (i >= 1 && i <= 10) begin
                chk($sformatf("wrap[%0d].we", i),   32'(regf_we), 32'd1);
                chk($sformatf("wrap[%0d].rd_s", i), 32'(rd_s),    32'd4);
                chk($sformatf("wrap[%0d].rd_v", i), rd_v,         32'h100 + 32'(i - 1));
            end else begin
                chk($sformatf("wrap[%0d].we", i),   32'(regf_we), 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
